// File: rtl/bcd_to_binary_sm_seq.sv
// Iterative signed-BCD to N-bit binary converter, one digit per clock, MSD first.
// Define BCD2BIN_TWOS_COMP_EN for a two's-complement result instead of sign-magnitude.
module bcd_to_binary_sm_seq #(
    parameter int DIGITS = 3,
    parameter int N      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [4*(DIGITS+1)-1:0]   bcd_in,
    output logic                      busy,
    output logic                      done,
    output logic [N-1:0]              result,
    output logic                      invalid
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    // When the magnitude field is at least as wide as the accumulator, no BCD value can overflow.
    localparam bit OVF_POSSIBLE = (N - 1) < AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   shreg_q, shreg_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            bad_q, bad_d;
    logic            done_q, done_d;
    logic [N-1:0]    result_q, result_d;
    logic            invalid_q, invalid_d;

    logic [3:0]      top_digit;
    logic [63:0]     mag_ext;
    logic [63:0]     pos_limit;
    logic            fin_ovf;
    logic [N-1:0]    fin_value;
    logic            sign_nibble_unused;

    assign sign_nibble_unused = ^bcd_in[AW+2:AW];
    assign top_digit          = shreg_q[AW-1 -: 4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            bad_q     <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            bad_q     <= bad_d;
            done_q    <= done_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CONV;
            S_CONV: if (cnt_q == CW'(1)) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mag_ext   = 64'(acc_q);
        pos_limit = (64'd1 << (N - 1)) - 64'd1;
`ifdef BCD2BIN_TWOS_COMP_EN
        // Negative side reaches one further than the positive side; -0 folds to 0.
        fin_ovf   = OVF_POSSIBLE && (sign_q ? (mag_ext > pos_limit + 64'd1) : (mag_ext > pos_limit));
        fin_value = sign_q ? (N'(0) - mag_ext[N-1:0]) : mag_ext[N-1:0];
`else
        fin_ovf   = OVF_POSSIBLE && (mag_ext > pos_limit);
        fin_value = {sign_q, mag_ext[N-2:0]};
`endif
    end

    always_comb begin
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        bad_d     = bad_q;
        done_d    = 1'b0;
        result_d  = result_q;
        invalid_d = invalid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = bcd_in[AW-1:0];
                    sign_d  = bcd_in[AW+3];
                    acc_d   = '0;
                    cnt_d   = CW'(DIGITS);
                    bad_d   = 1'b0;
                end
            end
            S_CONV: begin
                acc_d   = (acc_q << 3) + (acc_q << 1) + AW'(top_digit);
                shreg_d = shreg_q << 4;
                cnt_d   = cnt_q - CW'(1);
                if (top_digit > 4'd9) bad_d = 1'b1;
            end
            S_FIN: begin
                done_d    = 1'b1;
                invalid_d = bad_q | fin_ovf;
                result_d  = (bad_q | fin_ovf) ? '0 : fin_value;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q == S_CONV) || (state_q == S_FIN);
        done    = done_q;
        result  = result_q;
        invalid = invalid_q;
    end

endmodule
